fp16_mul_sequencer: RTL

//  Multi-cycle IEEE-754 binary16 multiplier controller with one-operand-pair-in-flight valid/ready handshake.

---
 rtl/fp16_mul_sequencer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/fp16_mul_sequencer.sv
// Multi-cycle binary16 multiplier: classify, special-case short path, 11-step shift-add, normalise + RNE.
// Latency counts the accept cycle as cycle 0: out_valid in cycle 2 (special) or cycle 14 (multiply).
module fp16_mul_sequencer #(
    parameter logic [15:0] CANON_NAN        = 16'h7E00,
    parameter bit          PASS_NAN_PAYLOAD = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic [3:0]  flags,
    output logic        busy
);

    localparam int unsigned SIG_W      = 11;
    localparam int unsigned PROD_W     = 22;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned MUL_CYCLES = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASSIFY,
        S_MUL,
        S_NORM,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [15:0]         a_q, a_d, b_q, b_d;
    logic [PROD_W-1:0]   mcand_q, mcand_d;
    logic [SIG_W-1:0]    mplier_q, mplier_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic signed [6:0]   exp_q, exp_d;
    logic                sign_q, sign_d;
    logic [15:0]         result_q, result_d;
    logic [3:0]          flags_q, flags_d;
    logic                out_valid_q, in_ready_q, busy_q;

    // Operand classification; subnormals fall into the zero class (flush to zero).
    logic a_exp_ones, a_exp_zero, a_sig_zero, a_snan, a_qnan, a_nan, a_inf, a_zero;
    logic b_exp_ones, b_exp_zero, b_sig_zero, b_snan, b_qnan, b_nan, b_inf, b_zero;
    logic [15:0] nan_res;
    logic        sign_c;

    assign a_exp_ones = &a_q[14:10];
    assign a_exp_zero = ~|a_q[14:10];
    assign a_sig_zero = ~|a_q[9:0];
    assign a_snan     = a_exp_ones & ~a_sig_zero & ~a_q[9];
    assign a_qnan     = a_exp_ones & a_q[9];
    assign a_nan      = a_snan | a_qnan;
    assign a_inf      = a_exp_ones & a_sig_zero;
    assign a_zero     = a_exp_zero;

    assign b_exp_ones = &b_q[14:10];
    assign b_exp_zero = ~|b_q[14:10];
    assign b_sig_zero = ~|b_q[9:0];
    assign b_snan     = b_exp_ones & ~b_sig_zero & ~b_q[9];
    assign b_qnan     = b_exp_ones & b_q[9];
    assign b_nan      = b_snan | b_qnan;
    assign b_inf      = b_exp_ones & b_sig_zero;
    assign b_zero     = b_exp_zero;

    assign sign_c  = a_q[15] ^ b_q[15];
    assign nan_res = !PASS_NAN_PAYLOAD ? CANON_NAN
                   : (a_nan ? (a_q | 16'h0200) : (b_q | 16'h0200));

    // Normalise and round-to-nearest-even the finished product.
    logic [9:0]        norm_mant;
    logic              norm_guard, norm_sticky, norm_round_up;
    logic [10:0]       norm_mant_rnd;
    logic [9:0]        norm_mant_fin;
    logic signed [6:0] norm_exp, norm_exp_rnd;
    logic [15:0]       norm_result;
    logic [3:0]        norm_flags;

    always_comb begin
        norm_mant     = acc_q[19:10];
        norm_guard    = acc_q[9];
        norm_sticky   = |acc_q[8:0];
        norm_exp      = exp_q;
        if (acc_q[21]) begin
            norm_mant   = acc_q[20:11];
            norm_guard  = acc_q[10];
            norm_sticky = |acc_q[9:0];
            norm_exp    = exp_q + 7'sd1;
        end
        norm_round_up = norm_guard & (norm_sticky | norm_mant[0]);
        norm_mant_rnd = {1'b0, norm_mant} + {10'd0, norm_round_up};
        norm_exp_rnd  = norm_mant_rnd[10] ? norm_exp + 7'sd1 : norm_exp;
        norm_mant_fin = norm_mant_rnd[10] ? 10'd0 : norm_mant_rnd[9:0];

        if (norm_exp_rnd >= 7'sd31) begin
            norm_result = {sign_q, 5'h1F, 10'h000};
            norm_flags  = 4'b0101;
        end else if (norm_exp_rnd <= 7'sd0) begin
            norm_result = {sign_q, 15'h0000};
            norm_flags  = 4'b0011;
        end else begin
            norm_result = {sign_q, norm_exp_rnd[4:0], norm_mant_fin};
            norm_flags  = {3'b000, norm_guard | norm_sticky};
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        result_d = result_q;
        flags_d  = flags_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = S_CLASSIFY;
                end
            end
            S_CLASSIFY: begin
                sign_d  = sign_c;
                state_d = S_DONE;
                if (a_snan || b_snan) begin
                    result_d = nan_res;
                    flags_d  = 4'b1000;
                end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
                    result_d = CANON_NAN;
                    flags_d  = 4'b1000;
                end else if (a_qnan || b_qnan) begin
                    result_d = nan_res;
                    flags_d  = 4'b0000;
                end else if (a_inf || b_inf) begin
                    result_d = {sign_c, 5'h1F, 10'h000};
                    flags_d  = 4'b0000;
                end else if (a_zero || b_zero) begin
                    result_d = {sign_c, 15'h0000};
                    flags_d  = 4'b0000;
                end else begin
                    mcand_d  = {11'd0, 1'b1, a_q[9:0]};
                    mplier_d = {1'b1, b_q[9:0]};
                    acc_d    = '0;
                    cnt_d    = '0;
                    exp_d    = $signed({2'b00, a_q[14:10]}) + $signed({2'b00, b_q[14:10]}) - 7'sd15;
                    state_d  = S_MUL;
                end
            end
            S_MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                result_d = norm_result;
                flags_d  = norm_flags;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            result_q    <= 16'h0000;
            flags_q     <= 4'b0000;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= (state_d == S_DONE);
            in_ready_q  <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign busy      = busy_q;

endmodule
